// File: rtl/prog_loader_if.sv
// Load-side streaming interface for prog_loader: valid/ready word transfer
// with an end-of-program marker.
interface prog_loader_if #(
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned DATA_W = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [FUNC_W+DATA_W-1:0]   in_word;
  logic                       in_last;

  // Program source drives words into the loader
  modport master (
    output in_valid,
    output in_word,
    output in_last,
    input  in_ready
  );

  // Loader side
  modport slave (
    input  in_valid,
    input  in_word,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: writable 2^ADDR_W-entry program memory with a streaming load
// port and a combinational read port addressed by the PC. The CPU is held
// until the whole program has been accepted.
// Optional feature: define PROG_CHECKSUM_EN to require a trailing mod-2^W
// checksum word before the program is released (adds the CHK state and err).
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  prog_loader_if.slave        ld,
  input  logic                reload,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [FUNC_W-1:0]   funcao,
  output logic [DATA_W-1:0]   dado,
  output logic                cpu_hold,
  output logic                load_done,
  output logic [ADDR_W:0]     load_count,
  output logic                err
);

  localparam int unsigned WORD_W = FUNC_W + DATA_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CHK  = 2'd2,
    S_DONE = 2'd3
  } state_t;
  // State entered after the final program word
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd3
  } state_t;
  localparam state_t S_END = S_DONE;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_load_count;
  logic [CNT_W-1:0]     w_count_nxt;
  logic                 r_in_ready;
  logic                 r_cpu_hold;
  logic                 r_load_done;
  logic [WORD_W-1:0]    r_mem [DEPTH];
  logic                 w_xfer;
  logic                 w_end;
  logic                 w_we;
  logic [ADDR_W-1:0]    w_wr_addr;
`ifdef PROG_CHECKSUM_EN
  logic                 r_err;
  logic                 w_err_nxt;
  logic [WORD_W-1:0]    r_sum;
  logic [WORD_W-1:0]    w_sum_nxt;
`endif

  // A word moves when the source offers it and the loader is not in DONE;
  // the last address ends the load even without in_last.
  assign w_xfer    = ld.in_valid && r_in_ready;
  assign w_end     = ld.in_last || (r_load_count == CNT_W'(DEPTH - 1));
  assign w_wr_addr = r_load_count[ADDR_W-1:0];

  // Next-state and write-enable decode; reload overrides any transfer
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_load_count;
    w_we        = 1'b0;
`ifdef PROG_CHECKSUM_EN
    w_err_nxt   = r_err;
    w_sum_nxt   = r_sum;
`endif
    if (reload) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
`ifdef PROG_CHECKSUM_EN
      w_err_nxt   = 1'b0;
      w_sum_nxt   = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_xfer) begin
            w_we        = 1'b1;
            w_count_nxt = r_load_count + CNT_W'(1);
`ifdef PROG_CHECKSUM_EN
            w_sum_nxt   = r_sum + ld.in_word;
`endif
            w_state_nxt = w_end ? S_END : S_LOAD;
          end
        end
`ifdef PROG_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            if (ld.in_word == r_sum) begin
              w_err_nxt   = 1'b0;
              w_state_nxt = S_DONE;
            end else begin
              w_err_nxt   = 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_load_count <= '0;
      r_in_ready   <= 1'b1;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_load_count <= w_count_nxt;
      r_in_ready   <= (w_state_nxt != S_DONE);
      r_cpu_hold   <= (w_state_nxt != S_DONE);
      r_load_done  <= (w_state_nxt == S_DONE);
    end
  end

`ifdef PROG_CHECKSUM_EN
  // Running checksum of accepted program words and rejection flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      r_sum <= '0;
    end else begin
      r_err <= w_err_nxt;
      r_sum <= w_sum_nxt;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // Program storage; reset clears every word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_wr_addr] <= ld.in_word;
    end
  end

  // Combinational read port: function nibble to control, operand to X
  assign funcao      = r_mem[rd_addr][WORD_W-1 -: FUNC_W];
  assign dado        = r_mem[rd_addr][DATA_W-1:0];

  assign ld.in_ready = r_in_ready;
  assign cpu_hold    = r_cpu_hold;
  assign load_done   = r_load_done;
  assign load_count  = r_load_count;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Accepted words are pushed to a
// scoreboard with their expected address and later popped and compared
// against the read port. Checksum scenario builds with PROG_CHECKSUM_EN.
module tb_prog_loader;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] word;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reload;
  logic [3:0] rd_addr;
  logic [3:0] funcao;
  logic [3:0] dado;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] load_count;
  logic       err;

  int         checks   = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [7:0] m_mem [16];
  int         m_count  = 0;

  prog_loader_if #(.FUNC_W(4), .DATA_W(4)) ld ();

  prog_loader #(.ADDR_W(4), .FUNC_W(4), .DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld         (ld.slave),
    .reload     (reload),
    .rd_addr    (rd_addr),
    .funcao     (funcao),
    .dado       (dado),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_count (load_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, then return 1 time unit after the edge
  task automatic cycle(input logic v, input logic [7:0] w, input logic l, input logic rl);
    ld.in_valid = v;
    ld.in_word  = w;
    ld.in_last  = l;
    reload      = rl;
    @(posedge clk);
    #1;
    ld.in_valid = 1'b0;
    ld.in_last  = 1'b0;
    reload      = 1'b0;
  endtask

  // Model: record a word the loader is expected to accept
  task automatic accept(input logic [7:0] w);
    sb.push_back('{addr: 4'(m_count), word: w});
    m_mem[m_count] = w;
    m_count++;
  endtask

  task automatic model_reload();
    m_count = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld.in_valid = 1'b0; ld.in_word = '0; ld.in_last = 1'b0;
    reload = 1'b0; rd_addr = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ld.in_ready); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", load_done); end
    checks++; if (load_count !== 5'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", load_count); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== 8'h00) begin
        failures++; $display("FAIL rst_mem addr=%0d got=%h exp=00", a, {funcao, dado});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] words [3];
    words[0] = 8'h1A; words[1] = 8'h2B; words[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, ld.in_ready); end
      if (i == 2) begin
        checks++;
        if (cpu_hold !== 1'b1) begin failures++; $display("FAIL b2b_hold_pre got=%b exp=1", cpu_hold); end
      end
      cycle(1'b1, words[i], (i == 2), 1'b0);
      accept(words[i]);
    end
    checks++; if (load_count !== 5'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", load_count); end
    checks++; if (cpu_hold !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%b exp=0", cpu_hold); end
    checks++; if (ld.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready got=%b exp=0", ld.in_ready); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", load_done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b exp=0", err); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL b2b_read addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
    rd_addr = 4'd3;
    @(negedge clk);
    checks++;
    if ({funcao, dado} !== m_mem[3]) begin failures++; $display("FAIL b2b_unwritten got=%h exp=%h", {funcao, dado}, m_mem[3]); end
  endtask

  task automatic test_full();
    exp_t e;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    model_reload();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      accept(8'h40 + 8'(i));
      if (i == 14) begin
        checks++;
        if (load_done !== 1'b0) begin failures++; $display("FAIL full_done_early got=%b exp=0", load_done); end
      end
    end
    checks++; if (load_count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", load_count); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", load_done); end
    checks++; if (ld.in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", ld.in_ready); end
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0);
    checks++; if (load_count !== 5'd16) begin failures++; $display("FAIL full_17_count got=%0d exp=16", load_count); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL full_read addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    model_reload();
    cycle(1'b1, 8'h5D, 1'b0, 1'b0); accept(8'h5D);
    cycle(1'b0, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 8'hEE, 1'b0, 1'b0);
    cycle(1'b1, 8'h6E, 1'b0, 1'b0); accept(8'h6E);
    cycle(1'b1, 8'h7F, 1'b0, 1'b0); accept(8'h7F);
    checks++; if (load_count !== 5'd3) begin failures++; $display("FAIL gap_count got=%0d exp=3", load_count); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL gap_hold got=%b exp=1", cpu_hold); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL gap_read addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
    rd_addr = 4'd3;
    @(negedge clk);
    checks++;
    if ({funcao, dado} !== m_mem[3]) begin failures++; $display("FAIL gap_addr3 got=%h exp=%h", {funcao, dado}, m_mem[3]); end
  endtask

  task automatic test_reload_collision();
    exp_t e;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    model_reload();
    cycle(1'b1, 8'h81, 1'b0, 1'b0); accept(8'h81);
    cycle(1'b1, 8'h92, 1'b0, 1'b0); accept(8'h92);
    cycle(1'b1, 8'hA3, 1'b0, 1'b1);
    model_reload();
    checks++; if (load_count !== 5'd0) begin failures++; $display("FAIL col_count got=%0d exp=0", load_count); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL col_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL col_done got=%b exp=0", load_done); end
    checks++; if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL col_ready got=%b exp=1", ld.in_ready); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL col_read addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
    rd_addr = 4'd2;
    @(negedge clk);
    checks++;
    if ({funcao, dado} !== m_mem[2]) begin failures++; $display("FAIL col_discard got=%h exp=%h", {funcao, dado}, m_mem[2]); end
  endtask

`ifdef PROG_CHECKSUM_EN
  task automatic test_checksum();
    exp_t e;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    model_reload();
    cycle(1'b1, 8'h10, 1'b0, 1'b0); accept(8'h10);
    cycle(1'b1, 8'h20, 1'b1, 1'b0); accept(8'h20);
    checks++; if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL chk_ready got=%b exp=1", ld.in_ready); end
    checks++; if (load_count !== 5'd2) begin failures++; $display("FAIL chk_count got=%0d exp=2", load_count); end
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL chk_bad_err got=%b exp=1", err); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL chk_bad_hold got=%b exp=1", cpu_hold); end
    checks++; if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL chk_bad_ready got=%b exp=1", ld.in_ready); end
    cycle(1'b1, 8'h30, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL chk_ok_err got=%b exp=0", err); end
    checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL chk_ok_done got=%b exp=1", load_done); end
    checks++; if (load_count !== 5'd2) begin failures++; $display("FAIL chk_ok_count got=%0d exp=2", load_count); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL chk_read addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
    rd_addr = 4'd2;
    @(negedge clk);
    checks++;
    if ({funcao, dado} !== m_mem[2]) begin failures++; $display("FAIL chk_nowrite got=%h exp=%h", {funcao, dado}, m_mem[2]); end
  endtask
`endif

  task automatic test_async_reset();
    exp_t e;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    model_reload();
    cycle(1'b1, 8'h55, 1'b0, 1'b0); accept(8'h55);
    cycle(1'b1, 8'h66, 1'b0, 1'b0); accept(8'h66);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      @(negedge clk);
      checks++;
      if ({funcao, dado} !== e.word) begin
        failures++; $display("FAIL ares_pre addr=%0d got=%h exp=%h", e.addr, {funcao, dado}, e.word);
      end
    end
    rd_addr = 4'd0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    model_reload();
    checks++; if ({funcao, dado} !== m_mem[0]) begin failures++; $display("FAIL ares_mem got=%h exp=%h", {funcao, dado}, m_mem[0]); end
    checks++; if (load_count !== 5'd0) begin failures++; $display("FAIL ares_count got=%0d exp=0", load_count); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL ares_hold got=%b exp=1", cpu_hold); end
    checks++; if (ld.in_ready !== 1'b1) begin failures++; $display("FAIL ares_ready got=%b exp=1", ld.in_ready); end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_gaps();
    test_reload_collision();
`ifdef PROG_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
